// File: rtl/crtc_timing.sv
`default_nettype none
// ============================================================================
// Module   : crtc_timing
// Purpose  : Character-based CRT controller timing generator. Produces the
//            horizontal character count, scanline-in-row count, row count,
//            vertical adjust scanlines, sync pulses, active windows, refresh
//            memory address and (optionally) a blinking text cursor.
// Ports    : pixel_clk          - sole clock, rising edge
//            reset_n            - asynchronous active-low reset
//            h_char_total/h_char_displayed/h_sync_pos/h_sync_width
//                               - horizontal timing (sync width 0 = 16)
//            v_char_height/v_adjust/v_char_total/v_char_displayed/
//            v_sync_pos/v_sync_width
//                               - vertical timing (sync width 0 = 16)
//            start_addr/cursor_addr - sampled only at frame wrap
//            cursor_start/cursor_end/cursor_mode - cursor shape and blink
//            addr_out, ra_out, h_sync, h_active, v_sync, v_active,
//            display_en, cursor, frame_start - registered outputs
// Options  : CRTC_CURSOR_EN - when defined, enables the cursor logic and the
//            blink frame counter; otherwise cursor is held at 0.
// Revision : 1.0 - initial release
// ============================================================================
module crtc_timing #(
    parameter int H_WIDTH  = 8,
    parameter int V_WIDTH  = 7,
    parameter int RA_WIDTH = 5,
    parameter int MA_WIDTH = 14
) (
    input  logic                pixel_clk,
    input  logic                reset_n,
    input  logic [H_WIDTH-1:0]  h_char_total,
    input  logic [H_WIDTH-1:0]  h_char_displayed,
    input  logic [H_WIDTH-1:0]  h_sync_pos,
    input  logic [3:0]          h_sync_width,
    input  logic [3:0]          v_sync_width,
    input  logic [RA_WIDTH-1:0] v_char_height,
    input  logic [RA_WIDTH-1:0] v_adjust,
    input  logic [V_WIDTH-1:0]  v_char_total,
    input  logic [V_WIDTH-1:0]  v_char_displayed,
    input  logic [V_WIDTH-1:0]  v_sync_pos,
    input  logic [MA_WIDTH-1:0] start_addr,
    input  logic [MA_WIDTH-1:0] cursor_addr,
    input  logic [RA_WIDTH-1:0] cursor_start,
    input  logic [RA_WIDTH-1:0] cursor_end,
    input  logic [1:0]          cursor_mode,
    output logic [MA_WIDTH-1:0] addr_out,
    output logic [RA_WIDTH-1:0] ra_out,
    output logic                h_sync,
    output logic                h_active,
    output logic                v_sync,
    output logic                v_active,
    output logic                display_en,
    output logic                cursor,
    output logic                frame_start
);

    // Counter state
    logic                r_run;        // 0 until the first edge after reset
    logic [H_WIDTH-1:0]  r_h;
    logic [RA_WIDTH-1:0] r_ra;         // scanline in row, or adjust index
    logic [V_WIDTH-1:0]  r_row;
    logic                r_in_adj;
    logic [MA_WIDTH-1:0] r_row_base;
    logic [4:0]          r_vs_left;    // v_sync scanlines remaining incl. current

    // Next-state values
    logic [H_WIDTH-1:0]  w_h_nxt;
    logic [RA_WIDTH-1:0] w_ra_nxt;
    logic [V_WIDTH-1:0]  w_row_nxt;
    logic                w_adj_nxt;
    logic [MA_WIDTH-1:0] w_base_nxt;
    logic [4:0]          w_vs_nxt;
    logic                w_frame_wrap;

    // Decoded outputs of the current counter state
    logic [4:0]          w_hs_width;
    logic [4:0]          w_vs_width;
    logic [H_WIDTH-1:0]  w_h_off;
    logic                w_h_act;
    logic                w_v_act;
    logic                w_hsync;
    logic                w_vsync;
    logic [MA_WIDTH-1:0] w_addr;
    logic                w_fs;
    logic                w_cursor;

    assign w_hs_width = (h_sync_width == 4'd0) ? 5'd16 : {1'b0, h_sync_width};
    assign w_vs_width = (v_sync_width == 4'd0) ? 5'd16 : {1'b0, v_sync_width};

    // All wrap tests use >= so a total reduced below the live count wraps
    // on the next compare instead of running to counter overflow. The first
    // edge after reset is handled as a frame wrap so that the address and
    // cursor latches load before the frame begins.
    always_comb begin
        w_h_nxt      = r_h + H_WIDTH'(1);
        w_ra_nxt     = r_ra;
        w_row_nxt    = r_row;
        w_adj_nxt    = r_in_adj;
        w_base_nxt   = r_row_base;
        w_vs_nxt     = r_vs_left;
        w_frame_wrap = 1'b0;
        if (!r_run) begin
            w_frame_wrap = 1'b1;
        end else if (r_h >= h_char_total) begin
            w_h_nxt = '0;
            if (!r_in_adj) begin
                if (r_ra >= v_char_height) begin
                    w_ra_nxt   = '0;
                    w_base_nxt = r_row_base + MA_WIDTH'(h_char_displayed);
                    if (r_row >= v_char_total) begin
                        if (v_adjust != '0) begin
                            w_adj_nxt = 1'b1;
                        end else begin
                            w_frame_wrap = 1'b1;
                        end
                    end else begin
                        w_row_nxt = r_row + V_WIDTH'(1);
                    end
                end else begin
                    w_ra_nxt = r_ra + RA_WIDTH'(1);
                end
            end else if (32'(r_ra) + 32'd1 >= 32'(v_adjust)) begin
                w_frame_wrap = 1'b1;
            end else begin
                w_ra_nxt = r_ra + RA_WIDTH'(1);
            end
            // v_sync is a whole-scanline property; it is (re)armed at the
            // first scanline of the sync row and then counts down.
            if (!w_adj_nxt && (w_row_nxt == v_sync_pos) && (w_ra_nxt == '0)) begin
                w_vs_nxt = w_vs_width;
            end else if (r_vs_left != 5'd0) begin
                w_vs_nxt = r_vs_left - 5'd1;
            end
        end
        if (w_frame_wrap) begin
            w_h_nxt    = '0;
            w_ra_nxt   = '0;
            w_row_nxt  = '0;
            w_adj_nxt  = 1'b0;
            w_base_nxt = start_addr;
            w_vs_nxt   = (v_sync_pos == '0) ? w_vs_width : 5'd0;
        end
    end

    always_comb begin
        w_h_off = r_h - h_sync_pos;
        w_h_act = (r_h < h_char_displayed);
        w_v_act = !r_in_adj && (r_row < v_char_displayed);
        w_hsync = (r_h >= h_sync_pos) && (32'(w_h_off) < 32'(w_hs_width));
        w_vsync = (r_vs_left != 5'd0);
        w_addr  = r_row_base + MA_WIDTH'(r_h);
        w_fs    = (r_h == '0) && (r_ra == '0) && (r_row == '0) && !r_in_adj;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run       <= 1'b0;
            r_h         <= '0;
            r_ra        <= '0;
            r_row       <= '0;
            r_in_adj    <= 1'b0;
            r_row_base  <= '0;
            r_vs_left   <= 5'd0;
            addr_out    <= '0;
            ra_out      <= '0;
            h_sync      <= 1'b0;
            h_active    <= 1'b0;
            v_sync      <= 1'b0;
            v_active    <= 1'b0;
            display_en  <= 1'b0;
            cursor      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r_run       <= 1'b1;
            r_h         <= w_h_nxt;
            r_ra        <= w_ra_nxt;
            r_row       <= w_row_nxt;
            r_in_adj    <= w_adj_nxt;
            r_row_base  <= w_base_nxt;
            r_vs_left   <= w_vs_nxt;
            // Outputs stay 0 on the latch edge that starts the first frame.
            addr_out    <= r_run ? w_addr : '0;
            ra_out      <= r_run ? r_ra : '0;
            h_sync      <= r_run && w_hsync;
            h_active    <= r_run && w_h_act;
            v_sync      <= r_run && w_vsync;
            v_active    <= r_run && w_v_act;
            display_en  <= r_run && w_h_act && w_v_act;
            cursor      <= r_run && w_cursor;
            frame_start <= r_run && w_fs;
        end
    end

`ifdef CRTC_CURSOR_EN
    logic [MA_WIDTH-1:0] r_cursor_lat;
    logic [5:0]          r_blink;      // frames since reset, mod 64
    logic                w_blink_on;

    always_comb begin
        case (cursor_mode)
            2'b00:   w_blink_on = 1'b1;
            2'b01:   w_blink_on = 1'b0;
            2'b10:   w_blink_on = !r_blink[4];
            default: w_blink_on = !r_blink[5];
        endcase
        w_cursor = w_h_act && w_v_act && (w_addr == r_cursor_lat) &&
                   (r_ra >= cursor_start) && (r_ra <= cursor_end) && w_blink_on;
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cursor_lat <= '0;
            r_blink      <= 6'd0;
        end else if (w_frame_wrap) begin
            r_cursor_lat <= cursor_addr;
            if (r_run) begin
                r_blink <= r_blink + 6'd1;
            end
        end
    end
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{cursor_addr, cursor_start, cursor_end, cursor_mode};
    assign w_cursor = 1'b0;
`endif

endmodule
`default_nettype wire
